// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchroniser plus a per-channel stability counter.
// Emits clean levels and one-cycle rise/fall/changed pulses, all registered.
module sw_debounce #(
  parameter int N_SW    = 4,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic            rst_meta_r;
  logic            rst_sync_r;
  logic [N_SW-1:0] s1_r;
  logic [N_SW-1:0] s2_r;
  logic [CNT_W-1:0] cnt_r     [N_SW];
  logic [CNT_W-1:0] cnt_nxt_s [N_SW];
  logic [N_SW-1:0] db_nxt_s;
  logic [N_SW-1:0] rise_nxt_s;
  logic [N_SW-1:0] fall_nxt_s;
  logic            changed_nxt_s;

  // Reset bridge: assertion is immediate, release is synchronised to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Input synchroniser, nothing between the two stages.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= sw_in;
      s2_r <= s1_r;
    end
  end

  // Per-channel next state: a match restarts the count, terminal count accepts.
  always_comb begin
    db_nxt_s   = sw_db;
    rise_nxt_s = '0;
    fall_nxt_s = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_nxt_s[i] = '0;
      if (s2_r[i] == sw_db[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] >= CNT_LAST) begin
        cnt_nxt_s[i]  = '0;
        db_nxt_s[i]   = s2_r[i];
        rise_nxt_s[i] = s2_r[i];
        fall_nxt_s[i] = ~s2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Pulse aggregation is combined before registering so all outputs share one edge.
  always_comb begin
    changed_nxt_s = |(rise_nxt_s | fall_nxt_s);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      for (int i = 0; i < N_SW; i++) begin
        cnt_r[i] <= '0;
      end
      sw_db      <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      sw_db      <= db_nxt_s;
      sw_rise    <= rise_nxt_s;
      sw_fall    <= fall_nxt_s;
      sw_changed <= changed_nxt_s;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with CNT_MAX=4; all expectations hand-computed
// from edge counts (inputs change just after a falling edge, so next rising edge is E0).
module tb_sw_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_changed;

  int n_checks;
  int n_pass;
  int rise_cnt [4];
  int fall_cnt [4];
  int chg_cnt;

  sw_debounce #(.N_SW(4), .CNT_MAX(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    chg_cnt = 0;
  endtask

  // Advance n cycles, sampling just after each falling edge and tallying pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        rise_cnt[i] += int'(sw_rise[i]);
        fall_cnt[i] += int'(sw_fall[i]);
      end
      chg_cnt += int'(sw_changed);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clr_pulses();
    rst_n = 1'b1;
    sw_in = 4'b1111;
    #2 rst_n = 1'b0;

    // Reset with switches held high; release is seen two edges later, so E5 is the 8th edge.
    step(3);
    check("rst_db", 32'(sw_db), 32'h0);
    check("rst_rise", 32'(sw_rise), 32'h0);
    check("rst_fall", 32'(sw_fall), 32'h0);
    check("rst_chg", 32'(sw_changed), 32'h0);
    rst_n = 1'b1;
    step(7);
    check("rel_db_e4", 32'(sw_db), 32'h0);
    step(1);
    check("rel_db_e5", 32'(sw_db), 32'hf);
    check("rel_rise_e5", 32'(sw_rise), 32'hf);
    check("rel_chg_e5", 32'(sw_changed), 32'h1);
    step(1);
    check("rel_rise_e6", 32'(sw_rise), 32'h0);
    check("rel_chg_e6", 32'(sw_changed), 32'h0);

    // All channels fall together.
    sw_in = 4'b0000;
    step(5);
    check("fall_db_e4", 32'(sw_db), 32'hf);
    step(1);
    check("fall_db_e5", 32'(sw_db), 32'h0);
    check("fall_pulse_e5", 32'(sw_fall), 32'hf);
    step(1);
    check("fall_pulse_e6", 32'(sw_fall), 32'h0);

    // Clean rise on channel 0.
    clr_pulses();
    sw_in = 4'b0001;
    step(5);
    check("c0_db_e4", 32'(sw_db), 32'h0);
    check("c0_rise_e4", 32'(sw_rise), 32'h0);
    step(1);
    check("c0_db_e5", 32'(sw_db), 32'h1);
    check("c0_rise_e5", 32'(sw_rise), 32'h1);
    step(1);
    check("c0_rise_e6", 32'(sw_rise), 32'h0);
    check("c0_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check("c0_fall_cnt", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);

    // Bounce on channel 2: 1,0,1,1,0,1 then held; only the final run of 1s is accepted.
    clr_pulses();
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 0; k < 6; k++) begin
        sw_in[2] = pat[k];
        step(1);
      end
    end
    step(4);
    check("b2_db_e4", 32'(sw_db), 32'h1);
    step(1);
    check("b2_db_e5", 32'(sw_db), 32'h5);
    check("b2_rise_e5", 32'(sw_rise), 32'h4);
    step(1);
    check("b2_rise_cnt", 32'(rise_cnt[2]), 32'd1);
    check("b2_fall_cnt", 32'(fall_cnt[2]), 32'd0);

    // Three-cycle glitch low on channel 1 is one short of acceptance.
    sw_in = 4'b0111;
    step(7);
    check("g1_setup_db", 32'(sw_db), 32'h7);
    clr_pulses();
    sw_in[1] = 1'b0;
    step(3);
    sw_in[1] = 1'b1;
    step(8);
    check("g1_db", 32'(sw_db), 32'h7);
    check("g1_fall_cnt", 32'(fall_cnt[1]), 32'd0);
    check("g1_chg_cnt", 32'(chg_cnt), 32'd0);
    check("g1_cnt", 32'(dut.cnt_r[1]), 32'd0);

    // Channel 0 rises and channel 3 falls on the same edge.
    sw_in = 4'b1110;
    step(7);
    check("sim_setup_db", 32'(sw_db), 32'he);
    clr_pulses();
    sw_in = 4'b0111;
    step(5);
    check("sim_rise_e4", 32'(sw_rise), 32'h0);
    check("sim_fall_e4", 32'(sw_fall), 32'h0);
    step(1);
    check("sim_rise_e5", 32'(sw_rise), 32'h1);
    check("sim_fall_e5", 32'(sw_fall), 32'h8);
    check("sim_chg_e5", 32'(sw_changed), 32'h1);
    check("sim_db_e5", 32'(sw_db), 32'h7);
    step(1);
    check("sim_rise_e6", 32'(sw_rise), 32'h0);
    check("sim_fall_e6", 32'(sw_fall), 32'h0);
    check("sim_chg_cnt", 32'(chg_cnt), 32'd1);

    // Reset at E3 of a pending rise on channel 3 discards it and clears outputs at once.
    sw_in = 4'b1111;
    step(4);
    rst_n = 1'b0;
    #1;
    check("mid_db_rst", 32'(sw_db), 32'h0);
    check("mid_pulse_rst", 32'({sw_rise, sw_fall, 3'b000, sw_changed}), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(7);
    check("mid_db_e4", 32'(sw_db), 32'h0);
    step(1);
    check("mid_db_e5", 32'(sw_db), 32'hf);
    check("mid_rise_e5", 32'(sw_rise), 32'hf);
    step(1);
    check("mid_chg_e6", 32'(sw_changed), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
